// File: rtl/aes_axil_regfile_pkg.sv
// Shared register map, bit positions and response codes for the AES IP register file.
package aes_ip_pkg;

    localparam logic [5:0] ADDR_CTRL    = 6'h00;
    localparam logic [5:0] ADDR_STATUS  = 6'h04;
    localparam logic [5:0] ADDR_KEY0    = 6'h08;
    localparam logic [5:0] ADDR_KEY1    = 6'h0C;
    localparam logic [5:0] ADDR_KEY2    = 6'h10;
    localparam logic [5:0] ADDR_KEY3    = 6'h14;
    localparam logic [5:0] ADDR_DIN0    = 6'h18;
    localparam logic [5:0] ADDR_DIN1    = 6'h1C;
    localparam logic [5:0] ADDR_DIN2    = 6'h20;
    localparam logic [5:0] ADDR_DIN3    = 6'h24;
    localparam logic [5:0] ADDR_DOUT0   = 6'h28;
    localparam logic [5:0] ADDR_DOUT1   = 6'h2C;
    localparam logic [5:0] ADDR_DOUT2   = 6'h30;
    localparam logic [5:0] ADDR_DOUT3   = 6'h34;
    localparam logic [5:0] ADDR_VERSION = 6'h38;

    localparam int unsigned CTRL_START   = 0;
    localparam int unsigned CTRL_MODE    = 1;
    localparam int unsigned CTRL_IRQ_EN  = 2;
    localparam int unsigned STATUS_BUSY  = 0;
    localparam int unsigned STATUS_DONE  = 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Merge new_val into old_val on the bytes enabled by strb.
    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] r;
        r = old_val;
        for (int unsigned i = 0; i < 4; i++) begin
            if (strb[i]) r[8*i +: 8] = new_val[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_axil_regfile_if.sv
// AXI4-Lite bus bundle for the AES register window.
interface aes_axil_regfile_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   S_AXI_AWADDR;
    logic [2:0]          S_AXI_AWPROT;
    logic                S_AXI_AWVALID;
    logic                S_AXI_AWREADY;
    logic [DATA_W-1:0]   S_AXI_WDATA;
    logic [DATA_W/8-1:0] S_AXI_WSTRB;
    logic                S_AXI_WVALID;
    logic                S_AXI_WREADY;
    logic [1:0]          S_AXI_BRESP;
    logic                S_AXI_BVALID;
    logic                S_AXI_BREADY;
    logic [ADDR_W-1:0]   S_AXI_ARADDR;
    logic [2:0]          S_AXI_ARPROT;
    logic                S_AXI_ARVALID;
    logic                S_AXI_ARREADY;
    logic [DATA_W-1:0]   S_AXI_RDATA;
    logic [1:0]          S_AXI_RRESP;
    logic                S_AXI_RVALID;
    logic                S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY
    );
endinterface

// File: rtl/aes_axil_regfile_axil_if.sv
// AXI4-Lite channel handshakes; presents a simple register-port view to the decode logic.
module aes_axil_if
    import aes_ip_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic                ACLK,
    input  logic                ARESET,
    aes_axil_regfile_if.slave   s_axi,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [DATA_W-1:0]   wr_data,
    output logic [DATA_W/8-1:0] wr_strb,
    input  logic                wr_err,
    output logic                rd_en,
    output logic [ADDR_W-1:0]   rd_addr,
    input  logic [DATA_W-1:0]   rd_data
);
    logic              awready;
    logic              arready;
    logic              bvalid;
    logic              rvalid;
    logic [1:0]        bresp;
    logic [1:0]        rresp;
    logic [DATA_W-1:0] rdata;
    logic              unused_prot;

    assign unused_prot = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT};

    assign wr_en   = awready & s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID;
    assign wr_addr = s_axi.S_AXI_AWADDR;
    assign wr_data = s_axi.S_AXI_WDATA;
    assign wr_strb = s_axi.S_AXI_WSTRB;
    assign rd_en   = arready & s_axi.S_AXI_ARVALID;
    assign rd_addr = s_axi.S_AXI_ARADDR;

    assign s_axi.S_AXI_AWREADY = awready;
    assign s_axi.S_AXI_WREADY  = awready;
    assign s_axi.S_AXI_BVALID  = bvalid;
    assign s_axi.S_AXI_BRESP   = bresp;
    assign s_axi.S_AXI_ARREADY = arready;
    assign s_axi.S_AXI_RVALID  = rvalid;
    assign s_axi.S_AXI_RRESP   = rresp;
    assign s_axi.S_AXI_RDATA   = rdata;

    // Write path: one-cycle AW/W ready pulse once both halves are present, then hold B until taken.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            awready <= 1'b0;
            bvalid  <= 1'b0;
            bresp   <= RESP_OKAY;
        end else begin
            awready <= !awready && s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID && !bvalid;
            if (wr_en) begin
                bvalid <= 1'b1;
                bresp  <= wr_err ? RESP_SLVERR : RESP_OKAY;
            end else if (bvalid && s_axi.S_AXI_BREADY) begin
                bvalid <= 1'b0;
            end
        end
    end

    // Read path: one-cycle AR ready pulse, registered data held until RREADY.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rresp   <= RESP_OKAY;
            rdata   <= '0;
        end else begin
            arready <= !arready && s_axi.S_AXI_ARVALID && !rvalid;
            if (rd_en) begin
                rvalid <= 1'b1;
                rresp  <= RESP_OKAY;
                rdata  <= rd_data;
            end else if (rvalid && s_axi.S_AXI_RREADY) begin
                rvalid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/aes_axil_regfile.sv
// AXI4-Lite register file fronting the AES-128 core: key/block latch, start pulse, result capture.
module aes_axil_regfile
    import aes_ip_pkg::*;
#(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 6,
    parameter logic [31:0] VERSION            = 32'h0001_0000
) (
    input  logic               ACLK,
    input  logic               ARESET,
    aes_axil_regfile_if.slave  s_axi,
    output logic               core_start,
    output logic               core_mode,
    output logic [127:0]       core_key,
    output logic [127:0]       core_din,
    input  logic               core_done,
    input  logic [127:0]       core_dout,
    output logic               irq
);
    logic                            wr_en;
    logic                            wr_err;
    logic                            rd_en;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   wr_addr;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   rd_addr;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   wr_word;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   rd_word;
    logic [C_S_AXI_DATA_WIDTH-1:0]   wr_data;
    logic [C_S_AXI_DATA_WIDTH-1:0]   rd_data;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] wr_strb;

    // Index 0 sits in the most significant word so the arrays map straight onto the core buses.
    logic [0:3][31:0] key;
    logic [0:3][31:0] din;
    logic [0:3][31:0] dout;
    logic             mode;
    logic             irq_en;
    logic             busy;
    logic             done;
    logic             start_pulse;
    logic             irq_q;
    logic             start_req;
    logic             done_clr;
    logic             unused_addr;

    aes_axil_if #(
        .ADDR_W(C_S_AXI_ADDR_WIDTH),
        .DATA_W(C_S_AXI_DATA_WIDTH)
    ) u_axil (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .s_axi  (s_axi),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .wr_strb(wr_strb),
        .wr_err (wr_err),
        .rd_en  (rd_en),
        .rd_addr(rd_addr),
        .rd_data(rd_data)
    );

    assign wr_word     = {wr_addr[C_S_AXI_ADDR_WIDTH-1:2], 2'b00};
    assign rd_word     = {rd_addr[C_S_AXI_ADDR_WIDTH-1:2], 2'b00};
    assign unused_addr = ^{wr_addr[1:0], rd_addr[1:0], rd_en};

    assign core_start = start_pulse;
    assign core_mode  = mode;
    assign core_key   = key;
    assign core_din   = din;
    assign irq        = irq_q;

    // Write qualification: operand/mode changes are refused while a run is in flight.
    always_comb begin
        wr_err    = 1'b0;
        start_req = 1'b0;
        done_clr  = 1'b0;
        if (busy) begin
            case (wr_word)
                ADDR_KEY0, ADDR_KEY1, ADDR_KEY2, ADDR_KEY3,
                ADDR_DIN0, ADDR_DIN1, ADDR_DIN2, ADDR_DIN3: wr_err = 1'b1;
                ADDR_CTRL: wr_err = wr_strb[0] && (wr_data[CTRL_MODE] != mode);
                default:   wr_err = 1'b0;
            endcase
        end
        if (wr_en && wr_strb[0]) begin
            start_req = (wr_word == ADDR_CTRL) && wr_data[CTRL_START] && !busy && !wr_err;
            done_clr  = (wr_word == ADDR_STATUS) && wr_data[STATUS_DONE];
        end
    end

    // Register state; later assignments win: W1C < core_done set < new start.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            key         <= '0;
            din         <= '0;
            dout        <= '0;
            mode        <= 1'b0;
            irq_en      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            start_pulse <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            start_pulse <= 1'b0;
            irq_q       <= done & irq_en;
            if (wr_en && !wr_err) begin
                case (wr_word)
                    ADDR_CTRL: begin
                        if (wr_strb[0]) begin
                            mode   <= wr_data[CTRL_MODE];
                            irq_en <= wr_data[CTRL_IRQ_EN];
                        end
                    end
                    ADDR_KEY0: key[0] <= apply_strb(key[0], wr_data, wr_strb);
                    ADDR_KEY1: key[1] <= apply_strb(key[1], wr_data, wr_strb);
                    ADDR_KEY2: key[2] <= apply_strb(key[2], wr_data, wr_strb);
                    ADDR_KEY3: key[3] <= apply_strb(key[3], wr_data, wr_strb);
                    ADDR_DIN0: din[0] <= apply_strb(din[0], wr_data, wr_strb);
                    ADDR_DIN1: din[1] <= apply_strb(din[1], wr_data, wr_strb);
                    ADDR_DIN2: din[2] <= apply_strb(din[2], wr_data, wr_strb);
                    ADDR_DIN3: din[3] <= apply_strb(din[3], wr_data, wr_strb);
                    default: ;
                endcase
            end
            if (done_clr) done <= 1'b0;
            if (core_done) begin
                dout <= core_dout;
                busy <= 1'b0;
                done <= 1'b1;
            end
            if (start_req) begin
                start_pulse <= 1'b1;
                busy        <= 1'b1;
                done        <= 1'b0;
            end
        end
    end

    // Read decode from current (pre-edge) register values.
    always_comb begin
        rd_data = '0;
        case (rd_word)
            ADDR_CTRL:    rd_data = {29'b0, irq_en, mode, 1'b0};
            ADDR_STATUS:  rd_data = {30'b0, done, busy};
            ADDR_KEY0:    rd_data = key[0];
            ADDR_KEY1:    rd_data = key[1];
            ADDR_KEY2:    rd_data = key[2];
            ADDR_KEY3:    rd_data = key[3];
            ADDR_DIN0:    rd_data = din[0];
            ADDR_DIN1:    rd_data = din[1];
            ADDR_DIN2:    rd_data = din[2];
            ADDR_DIN3:    rd_data = din[3];
            ADDR_DOUT0:   rd_data = dout[0];
            ADDR_DOUT1:   rd_data = dout[1];
            ADDR_DOUT2:   rd_data = dout[2];
            ADDR_DOUT3:   rd_data = dout[3];
            ADDR_VERSION: rd_data = VERSION;
            default:      rd_data = '0;
        endcase
    end

endmodule

// File: doc/aes_axil_regfile.md
# aes_axil_regfile

AXI4-Lite slave register file that fronts the AES-128 core inside the AES IP. The bus master sees it as a 64-byte register window. It latches the key and input block, issues a single-cycle start pulse to the core, and captures the core's output block on completion. It exposes busy/done status and a level interrupt.

## Interface
Parameters:
- C_S_AXI_DATA_WIDTH, 32, bus data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 6, byte address width of the 64-byte window.
- VERSION, 32'h0001_0000, value returned at 0x38.

Ports:
- ACLK  in  1  sole clock.
- ARESET  in  1  synchronous, active-high reset.
- S_AXI_AWADDR/AWPROT/AWVALID/AWREADY  in/in/in/out  6/3/1/1  write-address channel; AWPROT is ignored.
- S_AXI_WDATA/WSTRB/WVALID/WREADY  in/in/in/out  32/4/1/1  write-data channel.
- S_AXI_BRESP/BVALID/BREADY  out/out/in  2/1/1  write-response channel.
- S_AXI_ARADDR/ARPROT/ARVALID/ARREADY  in/in/in/out  6/3/1/1  read-address channel.
- S_AXI_RDATA/RRESP/RVALID/RREADY  out/out/out/in  32/2/1/1  read-data channel.
- core_start  out  1  one-cycle start pulse to the core.
- core_mode  out  1  0 = encrypt, 1 = decrypt.
- core_key  out  128  key; KEY0 drives bits [127:96].
- core_din  out  128  input block; DIN0 drives bits [127:96].
- core_done  in  1  one-cycle completion pulse from the core.
- core_dout  in  128  core result; valid in the core_done cycle.
- irq  out  1  level interrupt, equal to DONE & IRQ_EN.

## Operation
Register map (word aligned; ADDR[1:0] ignored):
- 0x00 CTRL, RW: bit0 START (write-1 pulse, reads 0), bit1 MODE, bit2 IRQ_EN.
- 0x04 STATUS: bit0 BUSY (RO), bit1 DONE (sticky, write-1-to-clear).
- 0x08–0x14 KEY0–KEY3, RW.
- 0x18–0x24 DIN0–DIN3, RW.
- 0x28–0x34 DOUT0–DOUT3, RO; loaded from core_dout on core_done.
- 0x38 VERSION, RO. 0x3C reads 0.

Write rules:
- WSTRB byte enables apply to every RW register.
- A write to KEY, DIN, or CTRL.MODE while BUSY=1 is dropped and answered with BRESP=SLVERR (2'b10). All other writes get OKAY.
- Writes to RO registers are ignored and answered with OKAY.
- START=1 written while BUSY=0:
  - core_start pulses in the next cycle.
  - BUSY is set in that same cycle.
  - DONE is cleared in that same cycle.
- START=1 written while BUSY=1 is ignored with OKAY.
- core_done: DOUT←core_dout, BUSY←0, DONE←1, all on the next edge.
- core_done with BUSY=0 is still captured as above.

## Timing
- Reset values:
  - AWREADY, WREADY, ARREADY, BVALID, RVALID, core_start, irq = 0.
  - BRESP, RRESP, RDATA = 0.
  - All registers 0, except VERSION.
- Write handshake:
  - AWREADY and WREADY rise together for exactly one cycle when AWVALID & WVALID & !BVALID.
  - The register update takes effect on that same edge.
  - BVALID asserts the following cycle and holds until BREADY.
  - There is no outstanding-address buffering: an AW without its W waits.
- Read handshake:
  - ARREADY pulses one cycle when ARVALID & !RVALID.
  - RDATA/RRESP are registered and RVALID asserts the next cycle, holding stable until RREADY.
  - Read latency is 1 cycle after the handshake.
- Read and write may handshake in the same cycle. The read returns the pre-write value.
- Simultaneous core_done and a DONE W1C: set wins, so DONE=1.
- Simultaneous core_done and a START write: BUSY is sampled before the edge.
  - START is ignored if BUSY=1.
  - Otherwise it starts a new run, and the start wins over the DONE set.
- irq is registered and follows DONE & IRQ_EN with 1 cycle of latency.
- ARESET asserted mid-transaction:
  - All valids and readies drop on the next edge and BUSY clears.
  - The core must be reset by the same ARESET.

## Structure
- aes_ip_pkg holds the register offset localparams (ADDR_CTRL … ADDR_VERSION), the CTRL/STATUS bit indices, and the RESP_OKAY/RESP_SLVERR constants.
- One sub-module, aes_axil_if, is natural. It implements the channel handshakes and BVALID/RVALID holding, and presents wr_en/wr_addr/wr_data/wr_strb/wr_err and rd_en/rd_addr/rd_data to the register-decode logic in the top.

## Test plan
- Reset, then read all 16 words → only 0x38 = 32'h0001_0000; the rest are 0, all with OKAY.
- Write KEY0..3 = 00010203, 04050607, 08090a0b, 0c0d0e0f; DIN0..3 = 00112233 … ccddeeff; CTRL = 32'h1. Expected:
  - core_start is high for exactly 1 cycle, with core_key = 000102…0f and core_din = 001122…ff.
  - STATUS reads 1.
- Core model pulses core_done with core_dout = 69c4e0d86a7b0430d8cdb78070b4c55a → DOUT0..3 read back as those words, and STATUS = 2.
- While BUSY, write KEY2 = 32'hdeadbeef → BRESP = 2'b10 and KEY2 is unchanged. A further write of CTRL = 1 produces no second core_start.
- CTRL = 32'h4 and DONE=1 → irq=1. Write STATUS = 2 → irq=0 one cycle later. Write STATUS = 2 in the same cycle as core_done → DONE stays 1.
- Write to KEY0 with WSTRB = 4'b0010 and data 32'hAABBCCDD onto 0 → reads 32'h0000CC00. Assert ARESET during BVALID → BVALID drops next cycle.
